// File: rtl/vec_pkg.sv
// Shared types for the vector execute unit: op codes, FSM states, element/vector helpers.
// Purely declarative; no logic, so no latency or backpressure of its own.
package vec_pkg;

    localparam int VEC_ELEM_WIDTH = 8;
    localparam int VEC_SIZE       = 6;

    typedef enum logic [2:0] {
        VOP_ADD = 3'b000,
        VOP_SUB = 3'b001,
        VOP_AND = 3'b010,
        VOP_OR  = 3'b011,
        VOP_XOR = 3'b100,
        VOP_SHL = 3'b101,
        VOP_SHR = 3'b110,
        VOP_MUL = 3'b111
    } vop_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vstate_e;

    typedef logic [VEC_ELEM_WIDTH-1:0]          elem_t;
    typedef logic [VEC_SIZE*VEC_ELEM_WIDTH-1:0] vec_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vector_lane_alu.sv
// Single-element unsigned ALU with optional add/sub saturation.
// Purely combinational: zero latency, no flow control.
module vector_lane_alu
    import vec_pkg::*;
#(
    parameter int ELEM_WIDTH = 8
) (
    input  logic [ELEM_WIDTH-1:0] i_a,
    input  logic [ELEM_WIDTH-1:0] i_b,
    input  vop_e                  i_op,
    input  logic                  i_sat,
    output logic [ELEM_WIDTH-1:0] o_y
);

    localparam int SHW = clog2_min1(ELEM_WIDTH);

    logic [ELEM_WIDTH:0]   w_sum;
    logic [ELEM_WIDTH:0]   w_diff;
    logic [ELEM_WIDTH-1:0] w_prod;
    logic [SHW-1:0]        w_sh;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_prod = i_a * i_b;
    assign w_sh   = i_b[SHW-1:0];

    always_comb begin
        o_y = '0;
        case (i_op)
            VOP_ADD: o_y = (i_sat && w_sum[ELEM_WIDTH]) ? {ELEM_WIDTH{1'b1}} : w_sum[ELEM_WIDTH-1:0];
            // Top bit of the widened difference is the borrow.
            VOP_SUB: o_y = (i_sat && w_diff[ELEM_WIDTH]) ? '0 : w_diff[ELEM_WIDTH-1:0];
            VOP_AND: o_y = i_a & i_b;
            VOP_OR:  o_y = i_a | i_b;
            VOP_XOR: o_y = i_a ^ i_b;
            VOP_SHL: o_y = i_a << w_sh;
            VOP_SHR: o_y = i_a >> w_sh;
            VOP_MUL: o_y = w_prod;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/vector_lane_unit.sv
// Multi-cycle vector execute unit: LANES elements per beat, result valid VECTOR_SIZE/LANES cycles after accept.
// Holds result while resultReady is low; accepts a new op in DONE only together with the result handshake.
module vector_lane_unit
    import vec_pkg::*;
#(
    parameter int ELEM_WIDTH  = 8,
    parameter int VECTOR_SIZE = 6,
    parameter int LANES       = 2,
    parameter int OP_WIDTH    = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              startValid,
    output logic                              startReady,
    input  logic [OP_WIDTH-1:0]               aluControl,
    input  logic                              saturate,
    input  logic                              useScalar,
    input  logic [VECTOR_SIZE*ELEM_WIDTH-1:0] operandA,
    input  logic [VECTOR_SIZE*ELEM_WIDTH-1:0] operandB,
    input  logic [ELEM_WIDTH-1:0]             scalarOperand,
    output logic                              resultValid,
    input  logic                              resultReady,
    output logic [VECTOR_SIZE*ELEM_WIDTH-1:0] result,
    output logic [VECTOR_SIZE-1:0]            zeroMask,
    output logic                              busy
);

    localparam int BEATS = VECTOR_SIZE / LANES;
    localparam int BW    = clog2_min1(BEATS);
    localparam int IW    = clog2_min1(VECTOR_SIZE);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (LANES < 1 || (VECTOR_SIZE % LANES) != 0) begin : g_bad_lanes
        $error("vector_lane_unit: LANES must divide VECTOR_SIZE");
    end
    if (OP_WIDTH < 3) begin : g_bad_opw
        $error("vector_lane_unit: OP_WIDTH must be at least 3");
    end

    vstate_e               r_state;
    logic [BW-1:0]         r_beat;
    logic [ELEM_WIDTH-1:0] r_a   [VECTOR_SIZE];
    logic [ELEM_WIDTH-1:0] r_b   [VECTOR_SIZE];
    logic [ELEM_WIDTH-1:0] r_res [VECTOR_SIZE];
    logic [VECTOR_SIZE-1:0] r_zmask;
    vop_e                  r_op;
    logic                  r_sat;
    logic                  r_result_vld;
    logic                  r_busy;

    logic                  w_start_rdy;
    logic                  w_accept;
    logic [IW-1:0]         w_idx    [LANES];
    logic [ELEM_WIDTH-1:0] w_lane_a [LANES];
    logic [ELEM_WIDTH-1:0] w_lane_b [LANES];
    logic [ELEM_WIDTH-1:0] w_lane_y [LANES];

    always_comb begin
        w_start_rdy = 1'b0;
        case (r_state)
            IDLE:    w_start_rdy = 1'b1;
            DONE:    w_start_rdy = resultReady;
            default: w_start_rdy = 1'b0;
        endcase
    end

    assign w_accept = startValid && w_start_rdy;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_idx[k]    = IW'(r_beat) * IW'(LANES) + IW'(k);
        assign w_lane_a[k] = r_a[w_idx[k]];
        assign w_lane_b[k] = r_b[w_idx[k]];

        vector_lane_alu #(
            .ELEM_WIDTH (ELEM_WIDTH)
        ) u_alu (
            .i_a   (w_lane_a[k]),
            .i_b   (w_lane_b[k]),
            .i_op  (r_op),
            .i_sat (r_sat),
            .o_y   (w_lane_y[k])
        );
    end

    // Operand capture has no reset: contents only matter after an accept.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                r_a[i] <= operandA[i*ELEM_WIDTH +: ELEM_WIDTH];
                r_b[i] <= useScalar ? scalarOperand : operandB[i*ELEM_WIDTH +: ELEM_WIDTH];
            end
            r_op  <= vop_e'(aluControl[2:0]);
            r_sat <= saturate;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_result_vld <= 1'b0;
            r_busy       <= 1'b0;
            r_zmask      <= '0;
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (startValid) begin
                        r_state <= RUN;
                        r_beat  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    for (int k = 0; k < LANES; k++) begin
                        r_res[w_idx[k]]   <= w_lane_y[k];
                        r_zmask[w_idx[k]] <= (w_lane_y[k] == '0);
                    end
                    if (r_beat == LAST_BEAT) begin
                        r_state      <= DONE;
                        r_beat       <= '0;
                        r_result_vld <= 1'b1;
                    end else begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                DONE: begin
                    if (resultReady) begin
                        r_result_vld <= 1'b0;
                        // A request arriving with the handshake skips the IDLE bubble.
                        if (startValid) begin
                            r_state <= RUN;
                            r_beat  <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_beat       <= '0;
                    r_result_vld <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_out
        assign result[i*ELEM_WIDTH +: ELEM_WIDTH] = r_res[i];
    end

    assign zeroMask    = r_zmask;
    assign resultValid = r_result_vld;
    assign busy        = r_busy;
    assign startReady  = w_start_rdy;

endmodule

// File: tb/tb_vector_lane_unit.sv
// Bench for vector_lane_unit: table vectors, handshake corner sequences and random ops against a reference model.
module tb_vector_lane_unit;

    localparam int EW  = 8;
    localparam int VS  = 6;
    localparam int LN  = 2;
    localparam int OPW = 3;
    localparam int VW  = VS * EW;

    logic          clock = 1'b0;
    logic          reset;
    logic          startValid;
    logic          startReady;
    logic [OPW-1:0] aluControl;
    logic          saturate;
    logic          useScalar;
    logic [VW-1:0] operandA;
    logic [VW-1:0] operandB;
    logic [EW-1:0] scalarOperand;
    logic          resultValid;
    logic          resultReady;
    logic [VW-1:0] result;
    logic [VS-1:0] zeroMask;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    vector_lane_unit #(
        .ELEM_WIDTH  (EW),
        .VECTOR_SIZE (VS),
        .LANES       (LN),
        .OP_WIDTH    (OPW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .startValid    (startValid),
        .startReady    (startReady),
        .aluControl    (aluControl),
        .saturate      (saturate),
        .useScalar     (useScalar),
        .operandA      (operandA),
        .operandB      (operandB),
        .scalarOperand (scalarOperand),
        .resultValid   (resultValid),
        .resultReady   (resultReady),
        .result        (result),
        .zeroMask      (zeroMask),
        .busy          (busy)
    );

    typedef struct {
        logic [2:0]    op;
        logic          sat;
        logic          usc;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [EW-1:0] sc;
        logic [VW-1:0] er;
        logic [VS-1:0] ez;
    } vec_rec_t;

    vec_rec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: each element treated as a plain integer 0..255.
    function automatic logic [VW-1:0] model(input logic [2:0] op, input logic sat, input logic usc,
                                            input logic [VW-1:0] a, input logic [VW-1:0] b,
                                            input logic [EW-1:0] sc);
        logic [VW-1:0] r;
        int x, y, z;
        r = '0;
        for (int i = 0; i < VS; i++) begin
            x = int'(a[i*EW +: EW]);
            y = usc ? int'(sc) : int'(b[i*EW +: EW]);
            z = 0;
            case (op)
                3'd0: begin z = x + y; if (z > 255) z = sat ? 255 : z - 256; end
                3'd1: begin z = x - y; if (z < 0)   z = sat ? 0   : z + 256; end
                3'd2: z = x & y;
                3'd3: z = x | y;
                3'd4: z = x ^ y;
                3'd5: z = (x << (y % 8)) % 256;
                3'd6: z = x >> (y % 8);
                default: z = (x * y) % 256;
            endcase
            r[i*EW +: EW] = z[7:0];
        end
        return r;
    endfunction

    function automatic logic [VS-1:0] zm_of(input logic [VW-1:0] r);
        logic [VS-1:0] m;
        for (int i = 0; i < VS; i++) m[i] = (r[i*EW +: EW] == 8'h00);
        return m;
    endfunction

    // Drives a request and returns #1 after the accepting edge.
    task automatic start_op(input logic [2:0] op, input logic sat, input logic usc,
                            input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [EW-1:0] sc);
        aluControl    = op;
        saturate      = sat;
        useScalar     = usc;
        operandA      = a;
        operandB      = b;
        scalarOperand = sc;
        startValid    = 1'b1;
        @(posedge clock);
        #1 startValid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            #1 lat++;
        end while (!resultValid && lat < 20);
    endtask

    initial begin
        logic [VW-1:0] exp_r, exp_r2, held;
        logic [63:0]   rnd;
        int            lat;
        logic [2:0]    op;
        logic          sat, usc;
        logic [VW-1:0] a, b;
        logic [EW-1:0] sc;

        tbl[0] = '{3'd0, 1'b0, 1'b0, 48'h060504030201, 48'h101010101010, 8'h00, 48'h161514131211, 6'h00};
        tbl[1] = '{3'd0, 1'b1, 1'b0, 48'hF0F0F0F0F0F0, 48'h202020202020, 8'h00, 48'hFFFFFFFFFFFF, 6'h00};
        tbl[2] = '{3'd0, 1'b0, 1'b0, 48'hF0F0F0F0F0F0, 48'h202020202020, 8'h00, 48'h101010101010, 6'h00};
        tbl[3] = '{3'd1, 1'b1, 1'b0, 48'h050505050505, 48'h090909090909, 8'h00, 48'h000000000000, 6'h3F};
        tbl[4] = '{3'd1, 1'b0, 1'b0, 48'h050505050505, 48'h090909090909, 8'h00, 48'hFCFCFCFCFCFC, 6'h00};
        tbl[5] = '{3'd7, 1'b0, 1'b1, 48'h060504030201, 48'hFFFFFFFFFFFF, 8'h03, 48'h120F0C090603, 6'h00};
        tbl[6] = '{3'd5, 1'b0, 1'b1, 48'h060504030201, 48'h000000000000, 8'h09, 48'h0C0A08060402, 6'h00};
        tbl[7] = '{3'd2, 1'b1, 1'b0, 48'hFF00FF00FF00, 48'h0F0F0F0F0F0F, 8'h00, 48'h0F000F000F00, 6'h15};
        tbl[8] = '{3'd6, 1'b0, 1'b0, 48'h808080808080, 48'h070605040302, 8'h00, 48'h010204081020, 6'h00};
        tbl[9] = '{3'd4, 1'b0, 1'b0, 48'h123456789ABC, 48'h123456789ABC, 8'h00, 48'h000000000000, 6'h3F};

        reset = 1'b1; startValid = 1'b0; resultReady = 1'b1;
        aluControl = '0; saturate = 1'b0; useScalar = 1'b0;
        operandA = '0; operandB = '0; scalarOperand = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_ctrl", {busy, resultValid, startReady}, 3'b001);
        chk("reset_result", result, '0);
        chk("reset_zmask", zeroMask, '0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start_op(tbl[i].op, tbl[i].sat, tbl[i].usc, tbl[i].a, tbl[i].b, tbl[i].sc);
            wait_valid(lat);
            chk($sformatf("tbl%0d_latency", i), lat, 3);
            chk($sformatf("tbl%0d_result", i), result, tbl[i].er);
            chk($sformatf("tbl%0d_zmask", i), zeroMask, tbl[i].ez);
            @(posedge clock);
            #1 chk($sformatf("tbl%0d_idle", i), {busy, resultValid, startReady}, 3'b001);
        end

        // Backpressure: result held, new requests refused.
        resultReady = 1'b0;
        start_op(3'd0, 1'b0, 1'b0, 48'h0A0B0C0D0E0F, 48'h010101010101, 8'h00);
        wait_valid(lat);
        chk("bp_latency", lat, 3);
        chk("bp_result", result, 48'h0B0C0D0E0F10);
        for (int c = 0; c < 5; c++) begin
            startValid = 1'b1; aluControl = 3'd7; operandA = 48'hFFFFFFFFFFFF; operandB = 48'h020202020202;
            @(posedge clock);
            #1;
            chk($sformatf("bp%0d_ctrl", c), {busy, resultValid, startReady}, 3'b110);
            chk($sformatf("bp%0d_result", c), result, 48'h0B0C0D0E0F10);
            chk($sformatf("bp%0d_zmask", c), zeroMask, 6'h00);
        end
        startValid = 1'b0; resultReady = 1'b1;
        @(posedge clock);
        #1 chk("bp_release", {busy, resultValid, startReady}, 3'b001);

        // Back-to-back: new request rides the result handshake.
        start_op(3'd3, 1'b0, 1'b0, 48'h010000000000, 48'h000000000080, 8'h00);
        wait_valid(lat);
        chk("b2b_first_result", result, 48'h010000000080);
        chk("b2b_first_zmask", zeroMask, 6'h1E);
        aluControl = 3'd0; saturate = 1'b1; useScalar = 1'b1;
        operandA = 48'hFE0102030405; scalarOperand = 8'h04; startValid = 1'b1;
        chk("b2b_start_rdy", startReady, 1'b1);
        @(posedge clock);
        #1 startValid = 1'b0;
        chk("b2b_no_idle", {busy, resultValid}, 2'b10);
        wait_valid(lat);
        chk("b2b_second_latency", lat, 3);
        chk("b2b_second_result", result, 48'hFF0506070809);
        @(posedge clock);
        #1;

        // Reset while RUN at beat 1.
        start_op(3'd7, 1'b0, 1'b0, 48'h020202020202, 48'h030303030303, 8'h00);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_ctrl", {busy, resultValid, startReady}, 3'b001);
        chk("rst_result", result, '0);
        chk("rst_zmask", zeroMask, '0);
        repeat (4) @(posedge clock);
        #1 chk("rst_no_emit", resultValid, 1'b0);
        start_op(3'd1, 1'b0, 1'b0, 48'h102030405060, 48'h010101010101, 8'h00);
        wait_valid(lat);
        chk("rst_after_latency", lat, 3);
        chk("rst_after_result", result, 48'h0F1F2F3F4F5F);
        @(posedge clock);
        #1;

        // Randomised ops with random consumer stalls.
        for (int n = 0; n < 30; n++) begin
            op  = 3'($urandom_range(0, 7));
            sat = 1'($urandom_range(0, 1));
            usc = 1'($urandom_range(0, 3) == 0);
            rnd = {$urandom(), $urandom()}; a = rnd[VW-1:0];
            rnd = {$urandom(), $urandom()}; b = rnd[VW-1:0];
            if ($urandom_range(0, 3) == 0) b = b & 48'h0F00FF0000FF;
            sc  = 8'($urandom_range(0, 255));
            exp_r = model(op, sat, usc, a, b, sc);
            resultReady = 1'($urandom_range(0, 1));
            start_op(op, sat, usc, a, b, sc);
            wait_valid(lat);
            chk($sformatf("rnd%0d_latency", n), lat, 3);
            held = result;
            repeat ($urandom_range(0, 3)) begin
                if (!resultReady) begin
                    @(posedge clock);
                    #1;
                end
            end
            chk($sformatf("rnd%0d_result", n), result, exp_r);
            chk($sformatf("rnd%0d_stable", n), result, held);
            chk($sformatf("rnd%0d_zmask", n), zeroMask, zm_of(exp_r));
            if (!resultReady) begin
                resultReady = 1'b1;
                @(posedge clock);
                #1;
            end else begin
                @(posedge clock);
                #1;
            end
            chk($sformatf("rnd%0d_idle", n), resultValid, 1'b0);
        end

        // Final random back-to-back pair through the model.
        a = 48'h8899AABBCCDD; b = 48'h112233445566;
        exp_r  = model(3'd7, 1'b0, 1'b0, a, b, 8'h00);
        exp_r2 = model(3'd0, 1'b1, 1'b0, exp_r, a, 8'h00);
        start_op(3'd7, 1'b0, 1'b0, a, b, 8'h00);
        wait_valid(lat);
        chk("pair_first", result, exp_r);
        aluControl = 3'd0; saturate = 1'b1; useScalar = 1'b0;
        operandA = exp_r; operandB = a; startValid = 1'b1;
        @(posedge clock);
        #1 startValid = 1'b0;
        wait_valid(lat);
        chk("pair_second_latency", lat, 3);
        chk("pair_second", result, exp_r2);
        @(posedge clock);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
